lcd_capture: RTL

Passive responder for the HD44780-style parallel LCD bus: samples LCD_E/LCD_RS/LCD_RW/LCD_DATA as driven by the LCD controller, decodes instruction and data writes, and maintains a 2×16 character image of the visible display plus controller-mode state. It sits beside the LCD controller, in place of or in parallel with the physical panel, so the keypad/LCD datapath can be read back and self-checked on-chip.

---
 rtl/lcd_capture.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_capture.sv
// lcd_capture: passive HD44780 bus snooper that keeps a 2xCOLS character image.
// Define LCD_CAPTURE_TIMING_CHECK_EN to enable the E high-width check.
module lcd_capture #(
    parameter int COLS       = 16,
    parameter int MIN_E_HIGH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       char_strobe,
    output logic       cmd_strobe,
    output logic [6:0] ddram_addr,
    output logic       disp_on,
    output logic       busy,
    output logic       overrun,
    output logic       rw_err,
    output logic       timing_err
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [6:0] L1_END = 7'(COLS);
    localparam logic [6:0] L2_BEG = 7'h40;
    localparam logic [6:0] L2_END = 7'(64 + COLS);

    if (COLS < 1 || COLS > 16) begin : g_bad_cols
        $error("lcd_capture: COLS must be 1..16");
    end
    if (MIN_E_HIGH < 1) begin : g_bad_min
        $error("lcd_capture: MIN_E_HIGH must be >= 1");
    end

    // {E, RS, RW, DATA}
    logic [10:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic        e_dly_q, e_dly_d;
    logic        fall_q, fall_d;
    logic        ev_rs_q, ev_rs_d;
    logic        ev_rw_q, ev_rw_d;
    logic [7:0]  ev_data_q, ev_data_d;

    state_t      state_q, state_d;
    logic [4:0]  clr_idx_q, clr_idx_d;
    logic [6:0]  cursor_q, cursor_d;
    logic        id_q, id_d;
    logic        disp_on_q, disp_on_d;
    logic        overrun_q, overrun_d;
    logic        rw_err_q, rw_err_d;
    logic        char_q, char_d;
    logic        cmd_q, cmd_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [7:0]  wr_val;
    logic [7:0]  buf_q [32];

    function automatic logic [6:0] step_addr(input logic [6:0] a,
                                             input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic visible(input logic [6:0] a);
        return (a < L1_END) || (a >= L2_BEG && a < L2_END);
    endfunction

    // Line 2 (0x40..) maps to buffer index 16.., i.e. addr - 0x30.
    function automatic logic [4:0] buf_index(input logic [6:0] a);
        return (a < L1_END) ? 5'(a) : 5'(a - 7'h30);
    endfunction

    always_comb begin
        sync1_d   = {LCD_E, LCD_RS, LCD_RW, LCD_DATA};
        sync2_d   = sync1_q;
        e_dly_d   = sync2_q[10];
        fall_d    = e_dly_q & ~sync2_q[10];
        ev_rs_d   = sync2_q[9];
        ev_rw_d   = sync2_q[8];
        ev_data_d = sync2_q[7:0];
        rd_data_d = buf_q[rd_addr];
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        cursor_d  = cursor_q;
        id_d      = id_q;
        disp_on_d = disp_on_q;
        overrun_d = overrun_q;
        rw_err_d  = rw_err_q;
        char_d    = 1'b0;
        cmd_d     = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = 5'd0;
        wr_val    = 8'h20;
        unique case (state_q)
            IDLE: begin
                if (fall_q) begin
                    if (ev_rw_q) begin
                        rw_err_d = 1'b1;
                    end else if (ev_rs_q) begin
                        char_d   = 1'b1;
                        wr_en    = visible(cursor_q);
                        wr_idx   = buf_index(cursor_q);
                        wr_val   = ev_data_q;
                        cursor_d = step_addr(cursor_q, id_q);
                    end else begin
                        cmd_d = 1'b1;
                        if (ev_data_q[7]) begin
                            cursor_d = ev_data_q[6:0];
                        end else if (ev_data_q[6] | ev_data_q[5]) begin
                            cursor_d = cursor_q;
                        end else if (ev_data_q[4]) begin
                            if (!ev_data_q[3])
                                cursor_d = step_addr(cursor_q, ev_data_q[2]);
                        end else if (ev_data_q[3]) begin
                            disp_on_d = ev_data_q[2];
                        end else if (ev_data_q[2]) begin
                            id_d = ev_data_q[1];
                        end else if (ev_data_q[1]) begin
                            cursor_d = 7'h00;
                        end else if (ev_data_q[0]) begin
                            cursor_d  = 7'h00;
                            id_d      = 1'b1;
                            clr_idx_d = 5'd0;
                            state_d   = CLEAR;
                        end
                    end
                end
            end
            CLEAR: begin
                wr_en     = 1'b1;
                wr_idx    = clr_idx_q;
                clr_idx_d = clr_idx_q + 5'd1;
                if (fall_q)
                    overrun_d = 1'b1;
                if (clr_idx_q == 5'd31)
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            e_dly_q   <= 1'b0;
            fall_q    <= 1'b0;
            ev_rs_q   <= 1'b0;
            ev_rw_q   <= 1'b0;
            ev_data_q <= 8'h00;
            state_q   <= IDLE;
            clr_idx_q <= 5'd0;
            cursor_q  <= 7'h00;
            id_q      <= 1'b1;
            disp_on_q <= 1'b0;
            overrun_q <= 1'b0;
            rw_err_q  <= 1'b0;
            char_q    <= 1'b0;
            cmd_q     <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            e_dly_q   <= e_dly_d;
            fall_q    <= fall_d;
            ev_rs_q   <= ev_rs_d;
            ev_rw_q   <= ev_rw_d;
            ev_data_q <= ev_data_d;
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            cursor_q  <= cursor_d;
            id_q      <= id_d;
            disp_on_q <= disp_on_d;
            overrun_q <= overrun_d;
            rw_err_q  <= rw_err_d;
            char_q    <= char_d;
            cmd_q     <= cmd_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++)
                buf_q[i] <= 8'h20;
        end else if (wr_en) begin
            buf_q[wr_idx] <= wr_val;
        end
    end

`ifdef LCD_CAPTURE_TIMING_CHECK_EN
    localparam int CW = $clog2(MIN_E_HIGH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MIN_E_HIGH);

    logic [CW-1:0] ehi_cnt_q, ehi_cnt_d;
    logic          terr_q, terr_d;

    always_comb begin
        ehi_cnt_d = ehi_cnt_q;
        if (!sync2_q[10])
            ehi_cnt_d = '0;
        else if (ehi_cnt_q < CNT_MAX)
            ehi_cnt_d = ehi_cnt_q + CW'(1);
        terr_d = terr_q | (fall_d & (ehi_cnt_q < CNT_MAX));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ehi_cnt_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            ehi_cnt_q <= ehi_cnt_d;
            terr_q    <= terr_d;
        end
    end

    assign timing_err = terr_q;
`else
    assign timing_err = 1'b0;
`endif

    assign rd_data     = rd_data_q;
    assign char_strobe = char_q;
    assign cmd_strobe  = cmd_q;
    assign ddram_addr  = cursor_q;
    assign disp_on     = disp_on_q;
    assign busy        = (state_q == CLEAR);
    assign overrun     = overrun_q;
    assign rw_err      = rw_err_q;

endmodule
